// File: rtl/ro_puf_sequencer_if.sv
// Signal bundle between the RO PUF sequencer and its surroundings: the run
// request, the ring-oscillator core controls/counts and the response handshake.
// The master modport is the sequencer's view, the slave modport the other side.
interface ro_puf_sequencer_if;
  logic        start;
  logic [47:0] challenge;
  logic        busy;
  logic [2:0]  ro_sel1;
  logic [2:0]  ro_sel2;
  logic        ro_enable;
  logic        ro_reset;
  logic [7:0]  ro_count_1;
  logic [7:0]  ro_count_2;
  logic [7:0]  resp;
  logic [7:0]  tie;
  logic        resp_valid;
  logic        resp_ready;

  modport master (
    input  start, challenge, ro_count_1, ro_count_2, resp_ready,
    output busy, ro_sel1, ro_sel2, ro_enable, ro_reset, resp, tie, resp_valid
  );

  modport slave (
    output start, challenge, ro_count_1, ro_count_2, resp_ready,
    input  busy, ro_sel1, ro_sel2, ro_enable, ro_reset, resp, tie, resp_valid
  );
endinterface

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: steps the RO core through eight challenge
// pairs (clear, run for WINDOW cycles, settle, sample), builds an 8-bit
// response plus tie flags and offers them on a valid/ready handshake.
// All core-facing outputs are flops so enable/reset/selects are glitch-free.
module ro_puf_sequencer #(
  parameter int unsigned WINDOW = 255,  // 1..65535
  parameter int unsigned SETTLE = 4     // 1..255
) (
  input  logic                clk,
  input  logic                reset_n,
  ro_puf_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [15:0] CLEAR_LAST  = 16'd1;
  localparam logic [15:0] RUN_LAST    = 16'(WINDOW - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q;
  logic [2:0]  idx_q;
  logic [2:0]  idx_next;
  logic [47:0] chal_q;
  logic [5:0]  pair_d;
  logic        handshake;

  assign handshake = bus.resp_valid & bus.resp_ready;
  assign idx_next  = idx_q + 3'd1;

  // Next-state logic: each timed state leaves when its cycle counter hits the last cycle.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start)                state_d = S_CLEAR;
      S_CLEAR:  if (timer_q == CLEAR_LAST)    state_d = S_RUN;
      S_RUN:    if (timer_q == RUN_LAST)      state_d = S_SETTLE;
      S_SETTLE: if (timer_q == SETTLE_LAST)   state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == 3'd7) ? S_DONE : S_CLEAR;
      S_DONE:   if (handshake)                state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Select pair loaded on entry to CLEAR: pair 0 comes straight from the
  // challenge port (it is latched on the same edge), later pairs from the latch.
  always_comb begin
    pair_d = chal_q[int'(idx_next) * 6 +: 6];
    if (state_q == S_IDLE) begin
      pair_d = bus.challenge[5:0];
    end
  end

  // State register and per-state cycle counter (cleared on every state change).
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == S_IDLE || state_q == S_DONE) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

  // Challenge latch, pair index and response/tie accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chal_q   <= '0;
      idx_q    <= '0;
      bus.resp <= '0;
      bus.tie  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            chal_q   <= bus.challenge;
            idx_q    <= '0;
            bus.resp <= '0;
            bus.tie  <= '0;
          end
        end
        S_SAMPLE: begin
          bus.resp[idx_q] <= (bus.ro_count_1 > bus.ro_count_2);
          bus.tie[idx_q]  <= (bus.ro_count_1 == bus.ro_count_2);
          if (idx_q != 3'd7) begin
            idx_q <= idx_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered core controls and status, decoded from the upcoming state so
  // they line up with the state they belong to; resp_valid drops on handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ro_sel1    <= '0;
      bus.ro_sel2    <= '0;
      bus.ro_enable  <= 1'b0;
      bus.ro_reset   <= 1'b1;
      bus.busy       <= 1'b0;
      bus.resp_valid <= 1'b0;
    end else begin
      if (state_d == S_CLEAR && state_q != S_CLEAR) begin
        bus.ro_sel1 <= pair_d[2:0];
        bus.ro_sel2 <= pair_d[5:3];
      end
      bus.ro_enable  <= (state_d == S_RUN);
      bus.ro_reset   <= (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DONE);
      bus.busy       <= (state_d != S_IDLE);
      bus.resp_valid <= (state_q == S_DONE) && !handshake;
    end
  end

endmodule
